// File: rtl/scpu_fetch_pkg.sv
// -----------------------------------------------------------------------------
// scpu_fetch_pkg
// Shared constants and types for the scpu instruction-fetch unit:
//   NOP_OPCODE        - word presented on fetch_ir while the prefetch queue is empty
//   RESET_PC_DEFAULT  - program counter value after reset
//   fetch_entry_t     - packed prefetch-queue entry {word, pc} at the default
//                       8-bit word / 8-bit address geometry
// -----------------------------------------------------------------------------
package scpu_fetch_pkg;

    localparam int unsigned NOP_OPCODE       = 32'h0000_0070;
    localparam int unsigned RESET_PC_DEFAULT = 32'h0000_0000;

    localparam int ENTRY_DW = 8;
    localparam int ENTRY_AW = 8;

    typedef struct packed {
        logic [ENTRY_DW-1:0] word;
        logic [ENTRY_AW-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/scpu_prefetch_fifo.sv
// -----------------------------------------------------------------------------
// scpu_prefetch_fifo
// Circular prefetch buffer for the fetch unit. Read/write pointers carry one
// extra wrap bit so that occupancy is simply their difference.
// Ports:
//   clk, rst   rising-edge clock, asynchronous active-high reset
//   i_push     write i_data at the tail (ignored when full)
//   i_pop      drop the head entry (ignored when empty)
//   i_flush    empty the buffer; wins over push and pop in the same cycle
//   i_data     entry to push
//   o_count    current occupancy, 0..DEPTH
//   o_head     entry at the head (meaningless when o_count is 0)
// -----------------------------------------------------------------------------
module scpu_prefetch_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  logic                         i_flush,
    input  logic [WIDTH-1:0]             i_data,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic [WIDTH-1:0]             o_head
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [IW:0]      r_wr_ptr;
    logic [IW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic [CW-1:0]    w_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    // Occupancy and guarded push/pop qualifiers.
    always_comb begin
        w_count   = r_wr_ptr - r_rd_ptr;
        w_push_ok = i_push && (w_count != CW'(DEPTH));
        w_pop_ok  = i_pop && (w_count != {CW{1'b0}});
    end

    // Pointer update; a flush returns both pointers to the origin.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= {(IW+1){1'b0}};
            r_rd_ptr <= {(IW+1){1'b0}};
        end else if (i_flush) begin
            r_wr_ptr <= {(IW+1){1'b0}};
            r_rd_ptr <= {(IW+1){1'b0}};
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + (IW+1)'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + (IW+1)'(1);
            end
        end
    end

    // Entry storage; contents need no reset because the head is only used when non-empty.
    always_ff @(posedge clk) begin
        if (w_push_ok && !i_flush) begin
            r_mem[r_wr_ptr[IW-1:0]] <= i_data;
        end
    end

    assign o_count = w_count;
    assign o_head  = r_mem[r_rd_ptr[IW-1:0]];

endmodule

// File: rtl/scpu_fetch_pq.sv
// -----------------------------------------------------------------------------
// scpu_fetch_pq
// Instruction-fetch unit with a DEPTH-entry prefetch queue. Owns the unified
// instruction/data RAM and the program counter. Prefetch runs whenever the
// queue has room and the data port is idle; dc_jump flushes and redirects.
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   fetch_ir            head instruction word (NOP when queue empty)
//   fetch_ir_pc         address of head word (0 when queue empty)
//   fetch_ir_valid      queue non-empty
//   dc_ir_ready         decoder takes the head this cycle
//   dc_jump, dc_target  flush the queue and load the PC
//   dc_mem_rd/wr        data-port read into fetch_dr / write of dc_wdata
//   dc_addr, dc_wdata   data-port address and write value
//   fetch_dr            last completed data read
//   fetch_count         queue occupancy
// -----------------------------------------------------------------------------
module scpu_fetch_pq
    import scpu_fetch_pkg::*;
#(
    parameter int          DW       = 8,
    parameter int          AW       = 8,
    parameter int          DEPTH    = 4,
    parameter int unsigned RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned NOP      = NOP_OPCODE
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic [DW-1:0]               fetch_ir,
    output logic [AW-1:0]               fetch_ir_pc,
    output logic                        fetch_ir_valid,
    input  logic                        dc_ir_ready,
    input  logic                        dc_jump,
    input  logic [AW-1:0]               dc_target,
    input  logic                        dc_mem_rd,
    input  logic                        dc_mem_wr,
    input  logic [AW-1:0]               dc_addr,
    input  logic [DW-1:0]               dc_wdata,
    output logic [DW-1:0]               fetch_dr,
    output logic [$clog2(DEPTH+1)-1:0]  fetch_count
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int EW = DW + AW;

    logic [DW-1:0] r_ram [2**AW];
    logic [AW-1:0] r_pc;
    logic [DW-1:0] r_dr;

    logic [CW-1:0] w_count;
    logic [EW-1:0] w_head;
    logic [EW-1:0] w_push_data;
    logic          w_valid;
    logic          w_push;
    logic          w_pop;

    // Prefetch arbitration: the data port and a redirect both pre-empt the fetch slot.
    always_comb begin
        w_valid     = (w_count != {CW{1'b0}});
        w_push      = (w_count < CW'(DEPTH)) && !dc_jump && !dc_mem_rd && !dc_mem_wr;
        w_pop       = w_valid && dc_ir_ready;
        w_push_data = {r_ram[r_pc], r_pc};
    end

    scpu_prefetch_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (dc_jump),
        .i_data  (w_push_data),
        .o_count (w_count),
        .o_head  (w_head)
    );

    // Unified RAM write port; contents survive reset by design.
    always_ff @(posedge clk) begin
        if (dc_mem_wr) begin
            r_ram[dc_addr] <= dc_wdata;
        end
    end

    // Program counter: redirect wins, otherwise advance only when a fetch was pushed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= AW'(RESET_PC);
        end else if (dc_jump) begin
            r_pc <= dc_target;
        end else if (w_push) begin
            r_pc <= r_pc + AW'(1);
        end
    end

    // Data register captures the pre-write RAM value, so rd+wr together returns old data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dr <= {DW{1'b0}};
        end else if (dc_mem_rd) begin
            r_dr <= r_ram[dc_addr];
        end
    end

    // Head presentation decoded from queue state; empty queue shows NOP at address 0.
    always_comb begin
        if (w_valid) begin
            fetch_ir    = w_head[EW-1:AW];
            fetch_ir_pc = w_head[AW-1:0];
        end else begin
            fetch_ir    = DW'(NOP);
            fetch_ir_pc = {AW{1'b0}};
        end
    end

    assign fetch_ir_valid = w_valid;
    assign fetch_count    = w_count;
    assign fetch_dr       = r_dr;

endmodule

// File: tb/tb_scpu_fetch_pq.sv
// -----------------------------------------------------------------------------
// tb_scpu_fetch_pq
// Self-checking bench for scpu_fetch_pq at DW=8, AW=8, DEPTH=4.
// -----------------------------------------------------------------------------
module tb_scpu_fetch_pq;
    import scpu_fetch_pkg::*;

    localparam int DEPTH = 4;
    localparam logic [7:0] NOPV = 8'h70;

    logic       clk;
    logic       rst;
    logic [7:0] fetch_ir;
    logic [7:0] fetch_ir_pc;
    logic       fetch_ir_valid;
    logic       dc_ir_ready;
    logic       dc_jump;
    logic [7:0] dc_target;
    logic       dc_mem_rd;
    logic       dc_mem_wr;
    logic [7:0] dc_addr;
    logic [7:0] dc_wdata;
    logic [7:0] fetch_dr;
    logic [2:0] fetch_count;

    int n_vec;
    int n_mis;

    scpu_fetch_pq #(
        .DW       (8),
        .AW       (8),
        .DEPTH    (DEPTH),
        .RESET_PC (0),
        .NOP      (32'h70)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_ir       (fetch_ir),
        .fetch_ir_pc    (fetch_ir_pc),
        .fetch_ir_valid (fetch_ir_valid),
        .dc_ir_ready    (dc_ir_ready),
        .dc_jump        (dc_jump),
        .dc_target      (dc_target),
        .dc_mem_rd      (dc_mem_rd),
        .dc_mem_wr      (dc_mem_wr),
        .dc_addr        (dc_addr),
        .dc_wdata       (dc_wdata),
        .fetch_dr       (fetch_dr),
        .fetch_count    (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a queue of {word, pc} records plus memory, PC and data register.
    fetch_entry_t mq[$];
    logic [7:0]   m_mem [256];
    logic [7:0]   m_pc;
    logic [7:0]   m_dr;

    typedef struct {
        logic       ready;
        logic       jump;
        logic [7:0] target;
        logic       rd;
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [2:0] e_count;
        logic [7:0] e_ir;
        logic [7:0] e_pc;
        logic       e_valid;
        logic [7:0] e_dr;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc = 8'h00;
        m_dr = 8'h00;
    endtask

    // One clock of the architectural rules, evaluated on pre-edge state.
    task automatic model_step(input logic ready, input logic jump, input logic [7:0] target,
                              input logic rd, input logic wr, input logic [7:0] addr,
                              input logic [7:0] wdata);
        int cnt0;
        fetch_entry_t e;
        cnt0 = mq.size();
        if (cnt0 > 0 && ready) void'(mq.pop_front());
        if (rd) m_dr = m_mem[addr];
        if (cnt0 < DEPTH && !jump && !rd && !wr) begin
            e.word = m_mem[m_pc];
            e.pc   = m_pc;
            mq.push_back(e);
            m_pc = m_pc + 8'd1;
        end
        if (jump) begin
            mq.delete();
            m_pc = target;
        end
        if (wr) m_mem[addr] = wdata;
    endtask

    task automatic check_model();
        logic [7:0] e_ir;
        logic [7:0] e_pc;
        if (mq.size() > 0) begin
            e_ir = mq[0].word;
            e_pc = mq[0].pc;
        end else begin
            e_ir = NOPV;
            e_pc = 8'h00;
        end
        chk("model_count", {29'd0, fetch_count}, mq.size());
        chk("model_valid", {31'd0, fetch_ir_valid}, {31'd0, (mq.size() > 0)});
        chk("model_ir", {24'd0, fetch_ir}, {24'd0, e_ir});
        chk("model_ir_pc", {24'd0, fetch_ir_pc}, {24'd0, e_pc});
        chk("model_dr", {24'd0, fetch_dr}, {24'd0, m_dr});
    endtask

    task automatic cycle(input logic ready, input logic jump, input logic [7:0] target,
                         input logic rd, input logic wr, input logic [7:0] addr,
                         input logic [7:0] wdata, input bit chk_model);
        dc_ir_ready = ready;
        dc_jump     = jump;
        dc_target   = target;
        dc_mem_rd   = rd;
        dc_mem_wr   = wr;
        dc_addr     = addr;
        dc_wdata    = wdata;
        model_step(ready, jump, target, rd, wr, addr, wdata);
        @(posedge clk);
        #1;
        if (chk_model) check_model();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] v;
        n_vec = 0;
        n_mis = 0;
        rst = 1'b1;
        dc_ir_ready = 1'b0; dc_jump = 1'b0; dc_target = 8'h00;
        dc_mem_rd = 1'b0; dc_mem_wr = 1'b0; dc_addr = 8'h00; dc_wdata = 8'h00;
        model_reset();
        #1;

        // Preload RAM through the data port while held in reset: mem[i] = i+10,
        // except mem[0x40]=0xAB and mem[0x81]=0x11.
        for (int i = 0; i < 256; i++) begin
            v = 8'(i + 10);
            if (i == 8'h40) v = 8'hAB;
            if (i == 8'h81) v = 8'h11;
            cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'(i), v, 1'b0);
        end
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

        do_reset();
        chk("reset_count", {29'd0, fetch_count}, 32'd0);
        chk("reset_ir", {24'd0, fetch_ir}, {24'd0, NOPV});

        //               rdy   jmp   tgt    rd    wr    addr   wdata  cnt   ir      pc     val   dr
        tbl[0]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 3'd1, 8'd10, 8'h00, 1'b1, 8'h00};
        tbl[1]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 3'd2, 8'd10, 8'h00, 1'b1, 8'h00};
        tbl[2]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 3'd3, 8'd10, 8'h00, 1'b1, 8'h00};
        tbl[3]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 3'd4, 8'd10, 8'h00, 1'b1, 8'h00};
        tbl[4]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 3'd4, 8'd10, 8'h00, 1'b1, 8'h00};
        tbl[5]  = '{1'b1, 1'b1, 8'h40, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 8'h70, 8'h00, 1'b0, 8'h00};
        tbl[6]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 3'd1, 8'hAB, 8'h40, 1'b1, 8'h00};
        tbl[7]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h80, 8'h55, 3'd1, 8'hAB, 8'h40, 1'b1, 8'h00};
        tbl[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h80, 8'h00, 3'd1, 8'hAB, 8'h40, 1'b1, 8'h55};
        tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h81, 8'h22, 3'd1, 8'hAB, 8'h40, 1'b1, 8'h11};
        tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h81, 8'h00, 3'd1, 8'hAB, 8'h40, 1'b1, 8'h22};
        tbl[11] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 3'd1, 8'h4B, 8'h41, 1'b1, 8'h22};
        tbl[12] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 3'd1, 8'h4C, 8'h42, 1'b1, 8'h22};

        for (int i = 0; i < 13; i++) begin
            cycle(tbl[i].ready, tbl[i].jump, tbl[i].target, tbl[i].rd, tbl[i].wr,
                  tbl[i].addr, tbl[i].wdata, 1'b0);
            chk($sformatf("tbl%0d_count", i), {29'd0, fetch_count}, {29'd0, tbl[i].e_count});
            chk($sformatf("tbl%0d_ir", i), {24'd0, fetch_ir}, {24'd0, tbl[i].e_ir});
            chk($sformatf("tbl%0d_pc", i), {24'd0, fetch_ir_pc}, {24'd0, tbl[i].e_pc});
            chk($sformatf("tbl%0d_valid", i), {31'd0, fetch_ir_valid}, {31'd0, tbl[i].e_valid});
            chk($sformatf("tbl%0d_dr", i), {24'd0, fetch_dr}, {24'd0, tbl[i].e_dr});
        end

        // PC wrap 0xFF -> 0x00 under continuous ready.
        cycle(1'b1, 1'b1, 8'hFE, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
        chk("wrap_flush_count", {29'd0, fetch_count}, 32'd0);
        cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
        chk("wrap_ir_fe", {16'd0, fetch_ir, fetch_ir_pc}, 32'h08FE);
        cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
        chk("wrap_ir_ff", {16'd0, fetch_ir, fetch_ir_pc}, 32'h09FF);
        cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
        chk("wrap_ir_00", {16'd0, fetch_ir, fetch_ir_pc}, 32'h0A00);

        // Asynchronous reset mid-cycle with three entries queued.
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
        chk("pre_async_count", {29'd0, fetch_count}, 32'd3);
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        chk("async_ir", {24'd0, fetch_ir}, {24'd0, NOPV});
        chk("async_valid", {31'd0, fetch_ir_valid}, 32'd0);
        chk("async_count", {29'd0, fetch_count}, 32'd0);
        chk("async_pc", {24'd0, fetch_ir_pc}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
        chk("post_async_first", {16'd0, fetch_ir, fetch_ir_pc}, 32'h0A00);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            cycle(1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 15) == 0),
                  8'($urandom_range(0, 255)),
                  1'($urandom_range(0, 7) == 0),
                  1'($urandom_range(0, 7) == 0),
                  8'($urandom_range(0, 255)),
                  8'($urandom_range(0, 255)),
                  1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
